multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle MIPS decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB states.
- Generates per-state datapath enables and handshakes with a variable-latency memory through mem_ready.
- Provides a bounded wait timeout, sticky bus-error state and illegal-opcode flag; sits between the IR and the shared-memory multi-cycle datapath.

Parameters:
- OPW, 6, OpCode width.
- FNW, 6, Funct width.
- TO_W, 8, width of the memory-wait timeout counter.
- TIMEOUT, 255, wait cycles tolerated before bus error (must be < 2**TO_W).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- OpCode  input  OPW  IR[31:26]; valid from ID onward.
- Funct  input  FNW  IR[5:0].
- mem_ready  input  1  memory completes the current access this cycle.
- state  output  3  current state (IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=5, IRQ=6).
- PCWrite  output  1  unconditional PC load.
- Branch  output  1  conditional PC load (datapath ANDs with ALU zero/cond).
- PCSrc  output  2  0=PC+4, 1=branch target, 2=jump target, 3=rs.
- IorD  output  1  0=PC address, 1=ALU-out address.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  load IR.
- RegWrite  output  1  register file write.
- RegDst  output  2  0=rd, 1=rt, 2=$31, 3=$26.
- MemtoReg  output  2  0=ALU, 1=MDR, 2=PC+4, 3=EPC.
- ALUSrc1  output  1  1=shamt (sll/srl/sra).
- ALUSrc2  output  1  1=immediate.
- ExtOp  output  1  1=sign-extend.
- LuOp  output  1  1=lui.
- illegal_op  output  1  one-cycle pulse in ID.
- bus_error  output  1  sticky; high in ERR.

Behaviour:
- Reset low: state=IF, timeout counter=0, latched class=NOP. All outputs are forced to 0 while reset is low. Reset mid-access abandons the access.
- Instruction classes (decoded in ID, registered for EX/MEM/WB):
  - R: op 0x00, excluding jr (Funct 0x08) and jalr (Funct 0x09).
  - LOAD: op 0x23.
  - STORE: op 0x2b.
  - BR: op 0x01 and 0x04–0x07.
  - J: op 0x02.
  - JAL: op 0x03.
  - IMM: op 0x08–0x0f.
  - All other opcodes are ILLEGAL.
- IF: MemRead=1, IorD=0. While mem_ready=0, hold state and increment the counter. On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, go to ID.
- ID:
  - J: PCWrite, PCSrc=2, go to IF.
  - JAL: J controls plus RegWrite, RegDst=2, MemtoReg=2, go to IF.
  - jr: PCWrite, PCSrc=3, go to IF.
  - jalr: PCWrite, PCSrc=3, RegWrite, RegDst=0, MemtoReg=2, go to IF.
  - ILLEGAL: illegal_op=1, go to IF; the instruction is a NOP.
  - All other classes go to EX.
- EX:
  - ALUSrc1, ALUSrc2, ExtOp and LuOp are valid here; they hold the single-cycle decode values for the latched opcode and are 0 in all other states.
  - BR: Branch=1, PCSrc=1, go to IF.
  - R/IMM go to WB; LOAD/STORE go to MEM.
- MEM: IorD=1; MemRead=1 for LOAD, MemWrite=1 for STORE. Controls are held until mem_ready. On mem_ready: STORE goes to IF, LOAD goes to WB.
- WB: RegWrite=1. RegDst=0 for R, 1 for IMM/LOAD. MemtoReg=1 for LOAD, 0 otherwise. Go to IF.
- Timeout counter:
  - Cleared on entry to IF or MEM, and on mem_ready.
  - If it equals TIMEOUT while mem_ready=0, next state is ERR.
  - mem_ready in the same cycle as count==TIMEOUT: ready wins.
- ERR: all enables 0, bus_error=1. ERR is absorbing; only reset exits it.
- Outputs are decoded from state and latched class plus live OpCode/Funct in ID (Moore-style except ID). There is no output register stage.
- The datapath must not change the IR while not in IF.

Optional Feature:
- Macro: MULTICYCLE_CTRL_IRQ_EN.
- With the macro defined:
  - Adds input irq (1 bit, level) and output irq_entry (1 bit).
  - On any transition into IF from ID, EX, MEM or WB with irq=1, the next state is IRQ instead.
  - IRQ lasts one cycle: irq_entry=1, PCWrite=1 (datapath selects the vector), RegWrite=1, RegDst=3, MemtoReg=3. It then goes to IF.
  - irq is ignored in IF and ERR.
- Without the macro: no irq/irq_entry ports, state 6 is never reached, and behaviour is otherwise identical.

Test Plan:
- lw (op 0x23) with mem_ready delayed 2 cycles in IF and 3 in MEM -> state sequence 0,0,0,1,2,3,3,3,3,4,0. RegWrite=1, MemtoReg=1, RegDst=1 only in WB.
- beq (op 0x04) -> Branch=1, PCSrc=1 in EX. Next state is IF, 3 states total.
- jal (op 0x03) -> in ID: PCWrite=1, PCSrc=2, RegWrite=1, RegDst=2, MemtoReg=2. Returns to IF with no EX.
- mem_ready held low in MEM with TIMEOUT=4 -> ERR after 5 MEM cycles, bus_error=1 and stays high. Reset low -> state=0, bus_error=0.
- op 0x3f -> illegal_op pulses one cycle in ID, no RegWrite/MemWrite, next IF.
- With MULTICYCLE_CTRL_IRQ_EN, irq=1 during WB of add -> state 6 for one cycle: irq_entry=1, RegDst=3, MemtoReg=3. Then IF.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB sequencer for a shared-memory MIPS datapath.
// Optional interrupt entry state enabled by defining MULTICYCLE_CTRL_IRQ_EN.
module multicycle_control #(
    parameter int OPW     = 6,
    parameter int FNW     = 6,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] OpCode,
    input  logic [FNW-1:0] Funct,
    input  logic           mem_ready,
`ifdef MULTICYCLE_CTRL_IRQ_EN
    input  logic           irq,
    output logic           irq_entry,
`endif
    output logic [2:0]     state,
    output logic           PCWrite,
    output logic           Branch,
    output logic [1:0]     PCSrc,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           IRWrite,
    output logic           RegWrite,
    output logic [1:0]     RegDst,
    output logic [1:0]     MemtoReg,
    output logic           ALUSrc1,
    output logic           ALUSrc2,
    output logic           ExtOp,
    output logic           LuOp,
    output logic           illegal_op,
    output logic           bus_error
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_ERR = 3'd5, S_IRQ = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_R, C_LOAD, C_STORE, C_BR, C_J,
        C_JAL, C_IMM, C_JR, C_JALR, C_ILL
    } cls_t;

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

    state_t          r_state;
    state_t          w_next;
    cls_t            r_cls;
    cls_t            w_cls;
    logic [OPW-1:0]  r_op;
    logic [FNW-1:0]  r_fn;
    logic [TO_W-1:0] r_cnt;
    logic            w_wait;

    // Classify the live IR fields; only meaningful while in ID.
    always_comb begin
        w_cls = C_ILL;
        unique case (1'b1)
            (OpCode == OPW'(0)) && (Funct == FNW'(8)): w_cls = C_JR;
            (OpCode == OPW'(0)) && (Funct == FNW'(9)): w_cls = C_JALR;
            (OpCode == OPW'(0)) && (Funct != FNW'(8))
                && (Funct != FNW'(9)):                   w_cls = C_R;
            OpCode == OPW'(8'h23):                     w_cls = C_LOAD;
            OpCode == OPW'(8'h2b):                     w_cls = C_STORE;
            (OpCode == OPW'(1))
                || ((OpCode >= OPW'(4)) && (OpCode <= OPW'(7))): w_cls = C_BR;
            OpCode == OPW'(2):                         w_cls = C_J;
            OpCode == OPW'(3):                         w_cls = C_JAL;
            (OpCode >= OPW'(8)) && (OpCode <= OPW'(15)): w_cls = C_IMM;
            default:                                   w_cls = C_ILL;
        endcase
    end

    // A memory-facing state that has not been answered yet this cycle.
    assign w_wait = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;

    // Next-state and per-state datapath controls; everything forced low in reset.
    always_comb begin
        w_next     = r_state;
        state      = 3'd0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'd0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 2'd0;
        MemtoReg   = 2'd0;
        ALUSrc1    = 1'b0;
        ALUSrc2    = 1'b0;
        ExtOp      = 1'b0;
        LuOp       = 1'b0;
        illegal_op = 1'b0;
        bus_error  = 1'b0;
`ifdef MULTICYCLE_CTRL_IRQ_EN
        irq_entry  = 1'b0;
`endif
        if (reset) begin
            state = r_state;
            case (r_state)
                S_IF: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = S_ID;
                    end
                end
                S_ID: begin
                    w_next = S_EX;
                    case (w_cls)
                        C_J: begin
                            PCWrite = 1'b1;
                            PCSrc   = 2'd2;
                            w_next  = S_IF;
                        end
                        C_JAL: begin
                            PCWrite  = 1'b1;
                            PCSrc    = 2'd2;
                            RegWrite = 1'b1;
                            RegDst   = 2'd2;
                            MemtoReg = 2'd2;
                            w_next   = S_IF;
                        end
                        C_JR: begin
                            PCWrite = 1'b1;
                            PCSrc   = 2'd3;
                            w_next  = S_IF;
                        end
                        C_JALR: begin
                            PCWrite  = 1'b1;
                            PCSrc    = 2'd3;
                            RegWrite = 1'b1;
                            MemtoReg = 2'd2;
                            w_next   = S_IF;
                        end
                        C_ILL: begin
                            illegal_op = 1'b1;
                            w_next     = S_IF;
                        end
                        default: w_next = S_EX;
                    endcase
                end
                S_EX: begin
                    ALUSrc1 = (r_cls == C_R) && ((r_fn == FNW'(0))
                              || (r_fn == FNW'(2)) || (r_fn == FNW'(3)));
                    ALUSrc2 = (r_cls == C_IMM) || (r_cls == C_LOAD)
                              || (r_cls == C_STORE);
                    ExtOp   = (r_cls == C_LOAD) || (r_cls == C_STORE)
                              || (r_cls == C_BR)
                              || ((r_cls == C_IMM) && (r_op < OPW'(8'h0c)));
                    LuOp    = (r_cls == C_IMM) && (r_op == OPW'(8'h0f));
                    case (r_cls)
                        C_BR: begin
                            Branch = 1'b1;
                            PCSrc  = 2'd1;
                            w_next = S_IF;
                        end
                        C_R, C_IMM:      w_next = S_WB;
                        C_LOAD, C_STORE: w_next = S_MEM;
                        default:         w_next = S_IF;
                    endcase
                end
                S_MEM: begin
                    IorD     = 1'b1;
                    MemRead  = (r_cls == C_LOAD);
                    MemWrite = (r_cls == C_STORE);
                    if (r_cls != C_LOAD && r_cls != C_STORE) begin
                        w_next = S_IF;
                    end else if (mem_ready) begin
                        w_next = (r_cls == C_LOAD) ? S_WB : S_IF;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = (r_cls == C_R) ? 2'd0 : 2'd1;
                    MemtoReg = (r_cls == C_LOAD) ? 2'd1 : 2'd0;
                    w_next   = S_IF;
                end
                S_ERR: begin
                    bus_error = 1'b1;
                    w_next    = S_ERR;
                end
                S_IRQ: begin
`ifdef MULTICYCLE_CTRL_IRQ_EN
                    irq_entry = 1'b1;
`endif
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    RegDst   = 2'd3;
                    MemtoReg = 2'd3;
                    w_next   = S_IF;
                end
                default: w_next = S_IF;
            endcase
            if (w_wait && (r_cnt == TO_MAX)) begin
                w_next = S_ERR;
            end
`ifdef MULTICYCLE_CTRL_IRQ_EN
            if (irq && (w_next == S_IF) && (r_state == S_ID
                || r_state == S_EX || r_state == S_MEM
                || r_state == S_WB)) begin
                w_next = S_IRQ;
            end
`endif
        end
    end

    // State, latched class/opcode and memory-wait counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IF;
            r_cls   <= C_NOP;
            r_op    <= '0;
            r_fn    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_cls <= w_cls;
                r_op  <= OpCode;
                r_fn  <= Funct;
            end
            if ((w_next != r_state)
                && (w_next == S_IF || w_next == S_MEM)) begin
                r_cnt <= '0;
            end else if (w_wait && (w_next == r_state)) begin
                r_cnt <= r_cnt + TO_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end
endmodule
